// File: rtl/if_id_control_pkg.sv
// Shared definitions for the IF/ID pipeline control slice.
// Holds branch opcodes, instruction field bit positions, the default
// bubble word, the control FSM state encoding and the IF/ID register
// update selector.
package if_id_control_pkg;

  localparam logic [3:0]  OP_JMP   = 4'hB;
  localparam logic [3:0]  OP_BZ    = 4'hC;

  localparam int          OP_MSB   = 31;
  localparam int          OP_LSB   = 28;
  localparam int          RS1_MSB  = 27;
  localparam int          RS1_LSB  = 24;
  localparam int          RS2_MSB  = 23;
  localparam int          RS2_LSB  = 20;
  localparam int          REG_W    = 4;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    IFID_LOAD,
    IFID_HOLD,
    IFID_BUBBLE
  } ifid_op_t;

endpackage

// File: rtl/if_id_control_hazard_detect.sv
// Load-use hazard detector (combinational).
// Flags a hazard when the ID slot holds a real instruction, the EX
// instruction is a load, and its destination matches either ID source.
// Register 0 is hard-wired and never creates a dependency.
// Ports:
//   id_valid  ID slot holds a real instruction
//   mem_read  EX instruction is a load
//   ex_rd     EX destination register
//   rs1, rs2  ID source registers
//   hazard    stall request
module if_id_control_hazard_detect
  import if_id_control_pkg::*;
(
  input  logic             id_valid,
  input  logic             mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             hazard
);

  logic rd_nonzero;
  logic rd_match;

  assign rd_nonzero = |ex_rd;
  assign rd_match   = (ex_rd == rs1) || (ex_rd == rs2);
  assign hazard     = id_valid && mem_read && rd_nonzero && rd_match;

endmodule

// File: rtl/if_id_control.sv
// IF/ID pipeline register with branch redirect and load-use stall control.
// A RUN/STALL/FLUSH FSM decides each cycle whether the IF/ID register
// loads the fetched word, holds, or takes a NOP bubble. Taken branches in
// ID redirect the PC combinationally; a load-use hazard freezes PC and
// IF/ID for two cycles and takes priority over a branch in the same slot.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   PC, Instruction  current fetch address and word
//   ZeroFlag         condition for BZ in ID
//   ExMemRead, ExRd  EX-stage load indicator and destination
//   Branch           select BranchAddr as next PC
//   BranchAddr       absolute target from ID instruction
//   PCWrite          PC register write enable
//   ID_PC, ID_Instruction, ID_Valid  IF/ID register contents
//   StallCount, FlushCount           saturating event counters
module if_id_control
  import if_id_control_pkg::*;
#(
  parameter int                ADDR_W = 12,
  parameter int                INST_W = 32,
  parameter logic [INST_W-1:0] NOP    = INST_W'(NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PC,
  input  logic [INST_W-1:0] Instruction,
  input  logic              ZeroFlag,
  input  logic              ExMemRead,
  input  logic [REG_W-1:0]  ExRd,
  output logic              Branch,
  output logic [ADDR_W-1:0] BranchAddr,
  output logic              PCWrite,
  output logic [ADDR_W-1:0] ID_PC,
  output logic [INST_W-1:0] ID_Instruction,
  output logic              ID_Valid,
  output logic [15:0]       StallCount,
  output logic [15:0]       FlushCount
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t     state, state_nxt;
  ifid_op_t   ifid_op;
  logic       stall_inc;
  logic       flush_inc;
  logic       hazard;
  logic       taken;
  logic [3:0] opcode;

  // ID stage decode
  assign opcode     = ID_Instruction[OP_MSB:OP_LSB];
  assign taken      = ID_Valid &&
                      ((opcode == OP_JMP) || ((opcode == OP_BZ) && ZeroFlag));
  assign Branch     = taken;
  assign BranchAddr = ID_Instruction[ADDR_W-1:0];

  if_id_control_hazard_detect u_hazard_detect (
    .id_valid (ID_Valid),
    .mem_read (ExMemRead),
    .ex_rd    (ExRd),
    .rs1      (ID_Instruction[RS1_MSB:RS1_LSB]),
    .rs2      (ID_Instruction[RS2_MSB:RS2_LSB]),
    .hazard   (hazard)
  );

  always_comb begin
    state_nxt = state;
    ifid_op   = IFID_LOAD;
    PCWrite   = 1'b1;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state)
      ST_RUN: begin
        // Hazard is checked first so a branch waiting on a load operand
        // is resolved only after the stall.
        if (hazard) begin
          PCWrite   = 1'b0;
          ifid_op   = IFID_HOLD;
          stall_inc = 1'b1;
          state_nxt = ST_STALL;
        end else if (taken) begin
          ifid_op   = IFID_BUBBLE;
          flush_inc = 1'b1;
          state_nxt = ST_FLUSH;
        end
      end
      ST_STALL: begin
        PCWrite   = 1'b0;
        ifid_op   = IFID_HOLD;
        stall_inc = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_FLUSH: begin
        // ID holds a bubble here, so neither branch nor hazard can fire;
        // the fetch already comes from the redirected target.
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // IF/ID register boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_RUN;
      ID_PC          <= '0;
      ID_Instruction <= NOP;
      ID_Valid       <= 1'b0;
      StallCount     <= '0;
      FlushCount     <= '0;
    end else begin
      state <= state_nxt;
      unique case (ifid_op)
        IFID_LOAD: begin
          ID_PC          <= PC;
          ID_Instruction <= Instruction;
          ID_Valid       <= 1'b1;
        end
        IFID_BUBBLE: begin
          ID_PC          <= PC;
          ID_Instruction <= NOP;
          ID_Valid       <= 1'b0;
        end
        default: ;
      endcase
      if (stall_inc) StallCount <= sat_inc(StallCount);
      if (flush_inc) FlushCount <= sat_inc(FlushCount);
    end
  end

endmodule

// File: doc/if_id_control.md
IF_ID_CONTROL -- requirements
Module: if_id_control

Interface
REQ-001 Parameter ADDR_W, default 12, program-counter and branch-target width.
REQ-002 Parameter INST_W, default 32, instruction width.
REQ-003 Parameter NOP, default 32'h0000_0000, instruction word loaded on bubble or flush.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 PC  in  ADDR_W  address of the word currently fetched.
REQ-007 Instruction  in  INST_W  fetched word for PC.
REQ-008 ZeroFlag  in  1  condition result for the conditional branch held in ID.
REQ-009 ExMemRead  in  1  instruction in EX is a load.
REQ-010 ExRd  in  4  destination register of that EX instruction.
REQ-011 Branch  out  1  select BranchAddr as next PC.
REQ-012 BranchAddr  out  ADDR_W  redirect target.
REQ-013 PCWrite  out  1  PC register write enable.
REQ-014 ID_PC  out  ADDR_W  registered PC of the ID instruction.
REQ-015 ID_Instruction  out  INST_W  registered instruction in ID.
REQ-016 ID_Valid  out  1  ID slot holds a real instruction, not a bubble.
REQ-017 StallCount  out  16  saturating count of load-use stall cycles.
REQ-018 FlushCount  out  16  saturating count of branch flushes.

Function
REQ-019 Opcode SHALL be ID_Instruction[31:28]; rs1 = [27:24], rs2 = [23:20]; 4'hB = JMP, 4'hC = BZ; target = ID_Instruction[ADDR_W-1:0], absolute.
REQ-020 Taken SHALL be ID_Valid and (opcode==JMP or (opcode==BZ and ZeroFlag)); Branch = taken, combinational; BranchAddr = target always.
REQ-021 Hazard SHALL be ID_Valid and ExMemRead and (ExRd==rs1 or ExRd==rs2); ExRd==0 never hazards.
REQ-022 FSM states SHALL be RUN, STALL, FLUSH; reset state RUN.
REQ-023 RUN, no hazard, not taken: PCWrite=1, IF/ID loads {PC, Instruction}, ID_Valid<=1.
REQ-024 RUN with hazard: PCWrite=0, IF/ID holds its contents, ID_Valid held, go STALL.
REQ-025 STALL SHALL last exactly one cycle: PCWrite=0, IF/ID held, then RUN with the hazard check re-evaluated.
REQ-026 RUN, taken, no hazard: PCWrite=1, IF/ID loads NOP with ID_Valid<=0, go FLUSH.
REQ-027 Hazard and taken together: hazard wins; branch is evaluated after the stall.
REQ-028 FLUSH: Branch=0 because ID_Valid=0; IF/ID loads target-path fetch; return to RUN; one-cycle penalty per taken branch.
REQ-029 StallCount SHALL increment once per cycle with PCWrite=0 due to hazard or STALL; FlushCount SHALL increment once per entry to FLUSH; both saturate at 16'hFFFF, no wrap.
REQ-030 Latency: Instruction at cycle N SHALL appear on ID_Instruction at cycle N+1 when not stalled or flushed.

Reset
REQ-031 Asserting rst at any time, including mid-STALL or mid-FLUSH, SHALL immediately force state RUN, ID_PC=0, ID_Instruction=NOP, ID_Valid=0, counters=0.
REQ-032 Consequently, during reset Branch=0 and PCWrite=1.
REQ-033 The first rising edge after deassertion SHALL capture {PC, Instruction}.

Structure
REQ-034 Shared package SHALL hold opcode constants JMP/BZ, field bit positions, FSM state enum, and NOP.
REQ-035 One sub-module SHALL be natural: hazard_detect, combinational; it contains the rs1/rs2-vs-ExRd compare and the ExRd==0 qualifier.
REQ-036 The IF/ID register, FSM, and counters SHALL remain in if_id_control.

Verification
REQ-037 Straight-line: PC 0,4,8 with non-branch words -> ID_PC 0,4,8 one cycle later; PCWrite=1 throughout; counters 0.
REQ-038 JMP: ID=32'hB000_0040 -> Branch=1, BranchAddr=12'h040; next ID_Valid=0 and FlushCount=1; following ID_PC=12'h040.
REQ-039 BZ: 32'hC000_0080 with ZeroFlag=0 -> Branch=0, no flush; repeat with ZeroFlag=1 -> Branch=1, BranchAddr=12'h080.
REQ-040 Load-use: ID rs1=3, ExMemRead=1, ExRd=3 -> PCWrite=0 for two cycles, ID contents held, StallCount=2; ExRd=0 -> no stall.
REQ-041 Hazard and taken JMP together -> stall first, then Branch=1 after STALL; FlushCount=1.
REQ-042 rst low mid-STALL -> outputs reset immediately; rst high -> RUN, capture next fetch; counters preset to 16'hFFFE saturate at 16'hFFFF.
